tx_encode: RTL

Transmit-side encoder and serializer for the simple-encoding link. It accepts 7-bit data words over a valid/ready handshake and appends the 3-bit inverted-popcount checksum to form a 10-bit frame. It then shifts the frame onto a single serial line with start and stop bits. It is the direct upstream partner of the RX decode stage, which checks frames of exactly this format.

---
 rtl/tx_pkg.sv | 30 +++
 rtl/tx_baud_counter.sv | 30 +++
 rtl/tx_encode.sv | 103 ++++++++++
 3 files changed

// File: rtl/tx_pkg.sv
// rtl/tx_pkg.sv - shared widths, FSM state type and checksum for the simple-encoding link
package tx_pkg;

    localparam int DATA_W  = 7;
    localparam int CHK_W   = 3;
    localparam int FRAME_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Inverted 3-bit wrap-around popcount of the payload; RX uses the same definition.
    function automatic logic [CHK_W-1:0] calc_chk(input logic [DATA_W-1:0] data);
        logic [CHK_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < DATA_W; i++) begin
            sum = sum + {{(CHK_W-1){1'b0}}, data[i]};
        end
        return sum ^ {CHK_W{1'b1}};
    endfunction

    // Frame layout: checksum in the top bits, payload in the bottom bits.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [DATA_W-1:0] data);
        return {calc_chk(data), data};
    endfunction

endpackage

// File: rtl/tx_baud_counter.sv
// rtl/tx_baud_counter.sv - bit-period timer producing one bit_tick every CLKS_PER_BIT cycles
module tx_baud_counter #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_tick
);

    // A one-cycle bit period still needs a 1-bit counter; it simply stays at 0.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign bit_tick = (cnt == LAST);

    // Count within the bit period; wrap on the tick, hold at 0 while restart is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tx_encode.sv
// rtl/tx_encode.sv - checksum encoder and start/stop serializer for the simple-encoding link
module tx_encode
    import tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  din,
    input  logic               din_valid,
    output logic               din_ready,
    output logic               tx_serial,
    output logic               tx_busy,
    output logic               frame_done,
    output logic [FRAME_W-1:0] frame_out
);

    localparam logic [3:0] LAST_BIT = 4'd9;

    tx_state_t          state;
    logic [FRAME_W-1:0] shreg;
    logic [3:0]         bit_cnt;
    logic               bit_tick;
    logic               accept;

    assign din_ready = (state == IDLE);
    assign accept    = din_valid && din_ready;

    // Holding the baud counter in IDLE means every state entry sees a fresh
    // bit period: START is entered from IDLE, the rest are entered on a wrap.
    tx_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (state == IDLE),
        .bit_tick (bit_tick)
    );

    // Frame FSM with registered line, busy and done outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            tx_serial  <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
            frame_out  <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx_serial <= 1'b1;
                    if (accept) begin
                        frame_out <= build_frame(din);
                        shreg     <= build_frame(din);
                        bit_cnt   <= '0;
                        tx_serial <= 1'b0;
                        tx_busy   <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        bit_cnt   <= '0;
                        tx_serial <= shreg[0];
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt   <= '0;
                            tx_serial <= 1'b1;
                            state     <= STOP;
                        end else begin
                            // Next bit is shreg[1]; the register shifts in step with the line.
                            bit_cnt   <= bit_cnt + 4'd1;
                            shreg     <= shreg >> 1;
                            tx_serial <= shreg[1];
                        end
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        bit_cnt    <= '0;
                        tx_serial  <= 1'b1;
                        tx_busy    <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    tx_serial <= 1'b1;
                    tx_busy   <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
